// File: rtl/doodle_physics_sequencer_pkg.sv
// Shared types and screen/physics constants for the doodle physics sequencer.
// Pure declarations, no logic.
package doodle_pkg;

  localparam int NUM_PLAT    = 12;
  localparam int JUMP_V      = 12;
  localparam int GRAVITY     = 1;
  localparam int MAX_FALL    = 10;
  localparam int DOODLE_R    = 10;
  localparam int PLAT_W      = 64;
  localparam int PLAT_H      = 16;
  localparam int SCROLL_LINE = 200;
  localparam int Y_TOP       = 35;
  localparam int Y_BOTTOM    = 515;
  localparam int Y_INIT      = 250;
  localparam int VEL_W       = 6;

  typedef logic signed [VEL_W-1:0] vel_t;

  localparam vel_t VEL_JUMP = vel_t'(-JUMP_V);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    MOVE      = 3'd2,
    SCAN      = 3'd3,
    SCROLL    = 3'd4,
    DEAD      = 3'd5
  } state_t;

endpackage

// File: rtl/doodle_physics_sequencer_if.sv
// Frame-control, platform-table and renderer signals of the physics sequencer.
// master = sequencer side, slave = game environment side.
interface doodle_physics_sequencer_if import doodle_pkg::*;;
  logic       frame_tick;
  logic       start;
  logic [9:0] doodle_x;
  logic [3:0] plat_idx;
  logic [9:0] plat_x;
  logic [9:0] plat_y;
  logic [9:0] doodle_y;
  vel_t       velocity;
  logic [9:0] scroll_offset;
  logic [15:0] score;
  logic       busy;
  logic       game_over;
  logic       overrun;

  modport master (
    input  frame_tick, start, doodle_x, plat_x, plat_y,
    output plat_idx, doodle_y, velocity, scroll_offset, score, busy, game_over, overrun
  );

  modport slave (
    output frame_tick, start, doodle_x, plat_x, plat_y,
    input  plat_idx, doodle_y, velocity, scroll_offset, score, busy, game_over, overrun
  );
endinterface

// File: rtl/doodle_physics_sequencer_plat_hit_check.sv
// Landing test of the doodle's feet against one platform; purely combinational.
module plat_hit_check
  import doodle_pkg::*;
(
  input  logic [9:0] doodle_x,
  input  logic [9:0] doodle_y,
  input  logic [9:0] plat_x,
  input  logic [9:0] plat_y,
  output logic       hit
);

  logic [10:0] foot;
  logic [10:0] dx;
  logic [10:0] px;
  logic [10:0] py;
  logic        hit_y;
  logic        hit_x;

  // Widened to 11 bits and the left bound moved to the doodle side so nothing wraps.
  always_comb begin
    foot  = {1'b0, doodle_y} + 11'(DOODLE_R);
    dx    = {1'b0, doodle_x};
    px    = {1'b0, plat_x};
    py    = {1'b0, plat_y};
    hit_y = (foot >= py) && (foot <= py + 11'(PLAT_H));
    hit_x = (dx + 11'(DOODLE_R) >= px) && (dx <= px + 11'(PLAT_W + DOODLE_R));
    hit   = hit_y && hit_x;
  end

endmodule

// File: rtl/doodle_physics_sequencer.sv
// Per-frame vertical physics: move, serial platform scan, world scroll.
// Busy 1 to NUM_PLAT+1 cycles per tick; ticks arriving while busy are dropped and flagged.
module doodle_physics_sequencer
  import doodle_pkg::*;
(
  input  logic clk,
  input  logic rst,
  doodle_physics_sequencer_if.master bus
);

  state_t      state_q, state_d;
  logic [9:0]  y_q, y_d;
  vel_t        vel_q, vel_d;
  logic [9:0]  off_q, off_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  idx_q, idx_d;
  logic        ovr_q, ovr_d;

  logic               hit;
  logic               busy_w;
  logic signed [10:0] sum_y;
  logic [9:0]         new_y;
  logic signed [6:0]  vel_inc;
  logic [9:0]         delta;
  logic [16:0]        score_sum;

  plat_hit_check u_hit (
    .doodle_x (bus.doodle_x),
    .doodle_y (y_q),
    .plat_x   (bus.plat_x),
    .plat_y   (bus.plat_y),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= 10'(Y_INIT);
      vel_q   <= '0;
      off_q   <= '0;
      score_q <= '0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      off_q   <= off_d;
      score_q <= score_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    off_d   = off_q;
    score_d = score_q;
    idx_d   = idx_q;

    busy_w    = (state_q == MOVE) || (state_q == SCAN) || (state_q == SCROLL);
    ovr_d     = ovr_q | (bus.frame_tick & busy_w);
    sum_y     = {1'b0, y_q} + {{5{vel_q[VEL_W-1]}}, vel_q};
    new_y     = (sum_y < $signed(11'(Y_TOP))) ? 10'(Y_TOP) : sum_y[9:0];
    vel_inc   = {vel_q[VEL_W-1], vel_q} + 7'(GRAVITY);
    delta     = 10'(SCROLL_LINE) - y_q;
    score_sum = {1'b0, score_q} + {7'b0, delta};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          vel_d   = VEL_JUMP;
          state_d = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (bus.frame_tick) state_d = MOVE;
      end
      MOVE: begin
        y_d   = new_y;
        vel_d = (vel_inc > $signed(7'(MAX_FALL))) ? vel_t'(MAX_FALL) : vel_inc[VEL_W-1:0];
        // Only a falling doodle can land; a rising one may need the world scrolled.
        if (!vel_q[VEL_W-1] && (vel_q != '0)) begin
          idx_d   = '0;
          state_d = SCAN;
        end else if (new_y < 10'(SCROLL_LINE)) begin
          state_d = SCROLL;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      SCAN: begin
        if (hit) begin
          y_d     = bus.plat_y - 10'(DOODLE_R);
          vel_d   = VEL_JUMP;
          idx_d   = '0;
          state_d = WAIT_TICK;
        end else if (idx_q == 4'(NUM_PLAT - 1)) begin
          idx_d = '0;
          if (({1'b0, y_q} + 11'(DOODLE_R)) > 11'(Y_BOTTOM)) begin
            vel_d   = '0;
            state_d = DEAD;
          end else begin
            state_d = WAIT_TICK;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      SCROLL: begin
        off_d   = off_q + delta;
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        y_d     = 10'(SCROLL_LINE);
        state_d = WAIT_TICK;
      end
      DEAD: begin
        if (bus.start) begin
          y_d     = 10'(Y_INIT);
          vel_d   = VEL_JUMP;
          off_d   = '0;
          score_d = '0;
          idx_d   = '0;
          state_d = WAIT_TICK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.plat_idx      = idx_q;
  assign bus.doodle_y      = y_q;
  assign bus.velocity      = vel_q;
  assign bus.scroll_offset = off_q;
  assign bus.score         = score_q;
  assign bus.busy          = busy_w;
  assign bus.game_over     = (state_q == DEAD);
  assign bus.overrun       = ovr_q;

endmodule

// File: tb/tb_doodle_physics_sequencer.sv
// Directed bench for doodle_physics_sequencer with a per-frame reference model and scoreboard.
module tb_doodle_physics_sequencer;

  typedef struct {
    int y;
    int v;
    int off;
    int score;
    int dead;
    int cyc;
  } exp_t;

  bit clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  doodle_physics_sequencer_if bus ();

  doodle_physics_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [9:0] tbl_x [16];
  logic [9:0] tbl_y [16];
  assign bus.plat_x = tbl_x[bus.plat_idx];
  assign bus.plat_y = tbl_y[bus.plat_idx];

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  int m_y, m_v, m_off, m_score, m_dead, m_hit;
  int obs_cyc, obs_last_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int sv(input logic signed [5:0] v);
    return int'(v);
  endfunction

  function automatic bit mhit(input int y, input int px, input int py, input int dx);
    return (y + 10 >= py) && (y + 10 <= py + 16) && (dx + 10 >= px) && (dx <= px + 64 + 10);
  endfunction

  task automatic model_reset();
    m_y = 250; m_v = 0; m_off = 0; m_score = 0; m_dead = 0; m_hit = -1;
  endtask

  task automatic model_frame(output exp_t e);
    int ny, pre, d;
    m_hit = -1;
    e.cyc = 0;
    if (m_dead == 0) begin
      pre = m_v;
      ny  = m_y + m_v;
      if (ny < 35) ny = 35;
      m_y = ny;
      m_v = (m_v + 1 > 10) ? 10 : m_v + 1;
      e.cyc = 1;
      if (pre > 0) begin
        for (int i = 0; i < 12; i++) begin
          e.cyc++;
          if (mhit(m_y, int'(tbl_x[i]), int'(tbl_y[i]), int'(bus.doodle_x))) begin
            m_hit = i;
            break;
          end
        end
        if (m_hit >= 0) begin
          m_y = int'(tbl_y[m_hit]) - 10;
          m_v = -12;
        end else if (m_y + 10 > 515) begin
          m_dead = 1;
          m_v = 0;
        end
      end else if (m_y < 200) begin
        e.cyc++;
        d = 200 - m_y;
        m_off = (m_off + d) % 1024;
        m_score = (m_score + d > 65535) ? 65535 : m_score + d;
        m_y = 200;
      end
    end
    e.y = m_y; e.v = m_v; e.off = m_off; e.score = m_score; e.dead = m_dead;
  endtask

  // Tick, then count busy cycles; optionally a second tick two cycles later.
  task automatic do_tick(input bit ovr);
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    obs_cyc = 0;
    obs_last_idx = 0;
    while (bus.busy === 1'b1 && obs_cyc < 40) begin
      obs_cyc++;
      obs_last_idx = int'(bus.plat_idx);
      bus.frame_tick = (ovr && obs_cyc == 2);
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
  endtask

  task automatic run_frame(input bit ovr);
    exp_t e;
    model_frame(e);
    sbq.push_back(e);
    do_tick(ovr);
    e = sbq.pop_front();
    chk("frame_y", bus.doodle_y, e.y);
    chk("frame_vel", sv(bus.velocity), e.v);
    chk("frame_scroll", bus.scroll_offset, e.off);
    chk("frame_score", bus.score, e.score);
    chk("frame_game_over", bus.game_over, e.dead);
    chk("frame_busy_cycles", obs_cyc, e.cyc);
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_y"}, bus.doodle_y, 250);
    chk({tag, "_vel"}, sv(bus.velocity), 0);
    chk({tag, "_scroll"}, bus.scroll_offset, 0);
    chk({tag, "_score"}, bus.score, 0);
    chk({tag, "_idx"}, bus.plat_idx, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_game_over"}, bus.game_over, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
  endtask

  initial begin
    int rise_y [6];
    int n, maxv;
    rise_y = '{238, 227, 217, 208, 200, 200};
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.doodle_x = 10'd700;
    for (int i = 0; i < 16; i++) begin tbl_x[i] = '0; tbl_y[i] = '0; end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    // Tick in IDLE is ignored.
    do_tick(1'b0);
    chk("idle_tick_busy", obs_cyc, 0);
    chk("idle_tick_y", bus.doodle_y, 250);

    // Rising and scrolling.
    pulse_start();
    m_v = -12;
    chk("start_vel", sv(bus.velocity), -12);
    for (int i = 0; i < 6; i++) begin
      run_frame(1'b0);
      chk("rise_y_const", bus.doodle_y, rise_y[i]);
    end
    chk("rise_scroll", bus.scroll_offset, 7);
    chk("rise_score", bus.score, 7);
    chk("rise_vel", sv(bus.velocity), -6);

    // start outside IDLE/DEAD is ignored.
    pulse_start();
    chk("start_ignored_vel", sv(bus.velocity), -6);
    chk("start_ignored_busy", bus.busy, 0);

    // Landing on platform 3.
    bus.doodle_x = 10'd450;
    tbl_x[3] = 10'd420; tbl_y[3] = 10'd290;
    n = 0;
    do begin run_frame(1'b0); n++; end while (m_hit < 0 && n < 40);
    chk("land_y", bus.doodle_y, 280);
    chk("land_vel", sv(bus.velocity), -12);
    chk("land_cycles", obs_cyc, 5);
    chk("land_last_idx", obs_last_idx, 3);
    chk("land_score", bus.score, 28);
    chk("land_idx_cleared", bus.plat_idx, 0);

    // Priority: idx 2 and 7 both overlap at the same scan.
    tbl_x[2] = 10'd400; tbl_y[2] = 10'd280;
    tbl_x[7] = 10'd420; tbl_y[7] = 10'd284;
    n = 0;
    do begin run_frame(1'b0); n++; end while (m_hit < 0 && n < 40);
    chk("prio_y", bus.doodle_y, 270);
    chk("prio_last_idx", obs_last_idx, 2);
    chk("prio_cycles", obs_cyc, 4);

    // Death with an overrun tick on the way down.
    for (int i = 0; i < 16; i++) begin tbl_x[i] = '0; tbl_y[i] = '0; end
    n = 0;
    while (m_v <= 0 && n < 40) begin run_frame(1'b0); n++; end
    chk("overrun_before", bus.overrun, 0);
    run_frame(1'b1);
    chk("overrun_set", bus.overrun, 1);
    chk("overrun_full_scan", obs_cyc, 13);
    maxv = sv(bus.velocity);
    n = 0;
    while (m_dead == 0 && n < 100) begin
      run_frame(1'b0);
      if (bus.game_over !== 1'b1 && sv(bus.velocity) > maxv) maxv = sv(bus.velocity);
      n++;
    end
    chk("dead_game_over", bus.game_over, 1);
    chk("dead_vel", sv(bus.velocity), 0);
    chk("dead_max_fall", maxv, 10);
    run_frame(1'b0);
    chk("dead_frozen_cycles", obs_cyc, 0);
    chk("dead_overrun_sticky", bus.overrun, 1);
    pulse_start();
    model_reset();
    m_v = -12;
    chk("restart_y", bus.doodle_y, 250);
    chk("restart_score", bus.score, 0);
    chk("restart_scroll", bus.scroll_offset, 0);
    chk("restart_game_over", bus.game_over, 0);
    chk("restart_vel", sv(bus.velocity), -12);
    chk("restart_overrun", bus.overrun, 1);

    // Asynchronous reset in the middle of a scan.
    n = 0;
    while (m_v <= 0 && n < 40) begin run_frame(1'b0); n++; end
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    n = 0;
    while (bus.plat_idx !== 4'd5 && n < 40) begin @(negedge clk); n++; end
    chk("arst_reached_idx5", bus.plat_idx, 5);
    #1 rst = 1'b1;
    #1 check_reset_values("arst");
    @(negedge clk) rst = 1'b0;
    model_reset();

    // Simultaneous start and tick in IDLE: start wins, tick dropped.
    @(negedge clk) begin bus.frame_tick = 1'b1; bus.start = 1'b1; end
    @(negedge clk) begin bus.frame_tick = 1'b0; bus.start = 1'b0; end
    chk("sim_start_busy", bus.busy, 0);
    chk("sim_start_vel", sv(bus.velocity), -12);
    chk("sim_start_y", bus.doodle_y, 250);
    m_v = -12;
    run_frame(1'b0);
    chk("sim_first_frame_y", bus.doodle_y, 238);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/doodle_physics_sequencer.md
Name: doodle_physics_sequencer

Overview:
- Per-frame game-physics controller for the doodle-jump datapath.
- Once per video frame it advances the doodle's vertical motion (jump impulse, gravity, terminal fall speed).
- It then scans the platform table serially for a landing and scrolls the world when the doodle rises above the scroll line.
- Drives doodle_y, scroll_offset and score into the VGA renderer; it handles vertical motion only.

Parameters:
- NUM_PLAT, 12, number of platform table entries scanned per frame
- JUMP_V, 12, upward speed after a bounce/start, px/frame
- GRAVITY, 1, velocity increment per frame
- MAX_FALL, 10, maximum downward velocity, px/frame
- DOODLE_R, 10, doodle half-size, px
- PLAT_W, 64, platform width, px
- PLAT_H, 16, platform height, px
- SCROLL_LINE, 200, screen y above which the world scrolls
- Y_TOP, 35, first visible line
- Y_BOTTOM, 515, last visible line
- Y_INIT, 250, doodle y after reset/restart

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- start  in  1  level/pulse; begins or restarts a game
- doodle_x  in  10  current doodle centre x
- plat_idx  out  4  platform table read address
- plat_x  in  10  left edge of platform[plat_idx], valid same cycle
- plat_y  in  10  top edge (screen space) of platform[plat_idx], valid same cycle
- doodle_y  out  10  doodle centre y (screen space)
- velocity  out  6  signed vertical velocity (negative = up)
- scroll_offset  out  10  cumulative world scroll, wraps mod 1024
- score  out  16  cumulative pixels climbed, saturates at 65535
- busy  out  1  high from frame_tick acceptance to return to WAIT_TICK
- game_over  out  1  high in DEAD
- overrun  out  1  sticky; frame_tick arrived while busy

Behaviour:
- Reset values: state=IDLE, doodle_y=Y_INIT, velocity=0, scroll_offset=0, score=0, plat_idx=0, busy=0, game_over=0, overrun=0.
- IDLE:
  - start=1 -> velocity=-JUMP_V, go to WAIT_TICK.
  - frame_tick is ignored in IDLE.
- WAIT_TICK: frame_tick=1 -> MOVE, busy=1.
- MOVE (1 cycle):
  - new_y = doodle_y + velocity, computed as 11-bit signed, clamped to >= Y_TOP.
  - velocity = min(velocity + GRAVITY, MAX_FALL), using the pre-update velocity.
  - Pre-update velocity > 0 -> SCAN with plat_idx=0.
  - Else if new_y < SCROLL_LINE -> SCROLL.
  - Else -> WAIT_TICK.
- SCAN (one entry per cycle, plat_idx 0..NUM_PLAT-1):
  - Hit when doodle_y+DOODLE_R is in [plat_y, plat_y+PLAT_H] and doodle_x is in [plat_x-DOODLE_R, plat_x+PLAT_W+DOODLE_R]. All compares are 11-bit unsigned with no wrap.
  - On hit: doodle_y = plat_y-DOODLE_R, velocity = -JUMP_V, plat_idx=0, go to WAIT_TICK (early exit). The lowest index wins.
  - No hit after the last index: plat_idx=0. If doodle_y+DOODLE_R > Y_BOTTOM -> DEAD, else -> WAIT_TICK.
- SCROLL (1 cycle):
  - delta = SCROLL_LINE - doodle_y.
  - scroll_offset += delta (mod 1024); score += delta (saturating); doodle_y = SCROLL_LINE.
  - Go to WAIT_TICK.
- DEAD:
  - game_over=1, velocity=0; outputs are frozen.
  - start=1 -> restore reset values except overrun, set velocity=-JUMP_V, go to WAIT_TICK.
- busy drops in the cycle the FSM enters WAIT_TICK.
- Worst-case latency from tick to not-busy is NUM_PLAT+1 cycles.
- frame_tick while busy is dropped and sets overrun; overrun is cleared only by rst.
- start outside IDLE/DEAD is ignored.
- A simultaneous frame_tick and start in IDLE/DEAD: start is taken and the tick is ignored.
- rst mid-SCAN or mid-SCROLL aborts immediately to reset values.

Decomposition:
- Shared package (doodle_pkg):
  - state enum (IDLE, WAIT_TICK, MOVE, SCAN, SCROLL, DEAD)
  - screen constants (Y_TOP, Y_BOTTOM, SCROLL_LINE)
  - DOODLE_R, PLAT_W, PLAT_H
  - velocity width (6)
- One natural sub-module: plat_hit_check. It is combinational: doodle_x, doodle_y, plat_x, plat_y -> hit.

Test Plan:
- Rising and scrolling:
  - Stimulus: rst; start; 6 ticks; no platform hit (plat_x=0, doodle_x=700).
  - doodle_y after ticks 1-5: 238, 227, 217, 208, 200.
  - Tick 6: doodle_y=200 after SCROLL, scroll_offset=7, score=7, velocity=-6.
- Landing:
  - Stimulus: platform 3 at plat_x=420, plat_y=290; doodle_x=450; play until falling.
  - First SCAN where doodle_y+10 is in [290,306] -> doodle_y=280, velocity=-12, scan ends at plat_idx=3 (busy for 5 cycles total).
- Death:
  - Stimulus: no platforms reachable.
  - velocity saturates at +10.
  - When doodle_y+10 > 515 -> game_over=1.
  - Further ticks leave doodle_y unchanged.
  - start -> doodle_y=250, score=0, game_over=0.
- Overrun:
  - Stimulus: frame_tick two cycles after a tick, during SCAN.
  - overrun=1, doodle_y unaffected by the second tick, overrun stays 1 until rst.
- Async reset mid-SCAN:
  - Stimulus: assert rst at plat_idx=5, between clock edges.
  - All outputs return to reset values immediately, with no clk edge needed.
- Priority: two platforms (idx 2 and 7) both overlap -> idx 2 chosen, plat_y taken from idx 2.
